ovc_allocator: RTL and testbench

// Per-output-port allocator: grants free downstream output VCs (OVCs) to input VCs that hold a head/single flit.
// It tracks per-OVC credit counts and gives each input VC the per-cycle credit-ok signal C.
// One instance per router output port.
// It sits between the input-port VC buffers (WAITING_FOR_OVC/ACTIVE FSMs) and the crossbar/link.

---
 rtl/router_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/ovc_allocator.sv | 155 +++++++++++++++
 tb/tb_ovc_allocator.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Router-wide constants and the output-VC state encoding shared by allocators.
package router_pkg;

    localparam int NUM_VC  = 4;
    localparam int NUM_OVC = 4;
    localparam int VC_SIZE = 8;

    localparam logic [3:0] NO_OVC = 4'hf;

    typedef enum logic [1:0] {
        OVC_FREE,
        OVC_BUSY,
        OVC_DRAIN
    } ovc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted req at or after ptr wins.
// Latency: combinational. Backpressure: none, the caller decides whether to consume the grant.
// Reused by the switch allocator.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 vld
);

    localparam int W = $clog2(N);

    logic [W-1:0] idx;

    // Walk from farthest to nearest so the candidate closest to ptr is written last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        vld     = 1'b0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ovc_allocator.sv
// Per-output-port OVC allocator with per-OVC credit counters and credit-ok to input VCs.
// Latency: req sampled at edge t gives a one-cycle grant pulse in cycle t+1.
// Backpressure: requests stay pending while no OVC is FREE; credit_ok gates senders per VC.
module ovc_allocator #(
    parameter int NUM_VC  = router_pkg::NUM_VC,
    parameter int NUM_OVC = router_pkg::NUM_OVC,
    parameter int VC_SIZE = router_pkg::VC_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_VC-1:0]          req,
    output logic [NUM_VC-1:0]          grant,
    output logic [3:0]                 grant_ovc,
    input  logic                       send_valid,
    input  logic [$clog2(NUM_VC)-1:0]  send_vc,
    input  logic                       send_tail,
    input  logic                       credit_valid,
    input  logic [$clog2(NUM_OVC)-1:0] credit_ovc,
    output logic [NUM_VC-1:0]          credit_ok,
    output logic [NUM_OVC-1:0]         ovc_free,
    output logic                       err
);

    import router_pkg::*;

    localparam int CRED_W = $clog2(VC_SIZE + 1);
    localparam int VC_W   = $clog2(NUM_VC);
    localparam int OVC_W  = $clog2(NUM_OVC);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(VC_SIZE);

    logic [NUM_VC-1:0]  owner_vld;
    logic [OVC_W-1:0]   owner_ovc [NUM_VC];
    ovc_state_t         ovc_state [NUM_OVC];
    ovc_state_t         ovc_state_nxt [NUM_OVC];
    logic [CRED_W-1:0]  credit [NUM_OVC];
    logic [CRED_W-1:0]  credit_nxt [NUM_OVC];
    logic [NUM_VC-1:0]  grant_q;
    logic [3:0]         grant_ovc_q;
    logic [VC_W-1:0]    rr_ptr;
    logic               err_q;

    logic               send_bound;
    logic [OVC_W-1:0]   send_ovc;
    logic [NUM_OVC-1:0] dec_vec;
    logic [NUM_OVC-1:0] inc_vec;
    logic [NUM_VC-1:0]  eligible;
    logic [NUM_VC-1:0]  arb_gnt;
    logic [VC_W-1:0]    arb_idx;
    logic               arb_vld;
    logic               free_any;
    logic [OVC_W-1:0]   free_idx;
    logic               do_grant;
    logic               err_set;

    assign send_bound = owner_vld[send_vc];
    assign send_ovc   = owner_ovc[send_vc];
    // A VC granted last cycle still shows req while its FSM leaves WAITING_FOR_OVC.
    assign eligible   = req & ~owner_vld & ~grant_q;

    rr_arbiter #(.N(NUM_VC)) u_arb (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .vld     (arb_vld)
    );

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int j = NUM_OVC - 1; j >= 0; j--) begin
            if (ovc_state[j] == OVC_FREE) begin
                free_any = 1'b1;
                free_idx = OVC_W'(j);
            end
        end
    end

    assign do_grant = arb_vld && free_any;

    always_comb begin
        dec_vec = '0;
        inc_vec = '0;
        for (int j = 0; j < NUM_OVC; j++) begin
            dec_vec[j] = send_valid && send_bound && (send_ovc == OVC_W'(j));
            inc_vec[j] = credit_valid && (credit_ovc == OVC_W'(j));
        end
    end

    always_comb begin
        err_set = send_valid && !send_bound;
        for (int j = 0; j < NUM_OVC; j++) begin
            credit_nxt[j]    = credit[j];
            ovc_state_nxt[j] = ovc_state[j];
            if (inc_vec[j] && !dec_vec[j]) begin
                if (credit[j] == CRED_MAX) err_set = 1'b1;
                else                       credit_nxt[j] = credit[j] + 1'b1;
            end else if (dec_vec[j] && !inc_vec[j]) begin
                if (credit[j] == '0) err_set = 1'b1;
                else                 credit_nxt[j] = credit[j] - 1'b1;
            end
            case (ovc_state[j])
                OVC_FREE:  if (do_grant && free_idx == OVC_W'(j)) ovc_state_nxt[j] = OVC_BUSY;
                OVC_BUSY:  if (dec_vec[j] && send_tail)
                               ovc_state_nxt[j] = (credit_nxt[j] == CRED_MAX) ? OVC_FREE : OVC_DRAIN;
                OVC_DRAIN: if (credit_nxt[j] == CRED_MAX) ovc_state_nxt[j] = OVC_FREE;
                default:   ovc_state_nxt[j] = OVC_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q     <= '0;
            grant_ovc_q <= NO_OVC;
            rr_ptr      <= '0;
            err_q       <= 1'b0;
            owner_vld   <= '0;
            for (int i = 0; i < NUM_VC; i++) owner_ovc[i] <= '0;
            for (int j = 0; j < NUM_OVC; j++) begin
                credit[j]    <= CRED_MAX;
                ovc_state[j] <= OVC_FREE;
            end
        end else begin
            grant_q     <= do_grant ? arb_gnt : '0;
            grant_ovc_q <= do_grant ? 4'(free_idx) : NO_OVC;
            if (err_set) err_q <= 1'b1;
            // The winner owns nothing, so it never collides with the tail release below.
            if (do_grant) begin
                rr_ptr              <= (arb_idx == VC_W'(NUM_VC - 1)) ? '0 : arb_idx + 1'b1;
                owner_vld[arb_idx]  <= 1'b1;
                owner_ovc[arb_idx]  <= free_idx;
            end
            if (send_valid && send_tail && send_bound) owner_vld[send_vc] <= 1'b0;
            for (int j = 0; j < NUM_OVC; j++) begin
                credit[j]    <= credit_nxt[j];
                ovc_state[j] <= ovc_state_nxt[j];
            end
        end
    end

    always_comb begin
        credit_ok = '0;
        for (int i = 0; i < NUM_VC; i++)
            credit_ok[i] = owner_vld[i] && (credit[owner_ovc[i]] != '0);
        ovc_free = '0;
        for (int j = 0; j < NUM_OVC; j++)
            ovc_free[j] = (ovc_state[j] == OVC_FREE);
    end

    assign grant     = grant_q;
    assign grant_ovc = grant_ovc_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ovc_allocator.sv
// Bench for ovc_allocator: directed scenarios plus random legal traffic against a rule-level model.
module tb_ovc_allocator;

    localparam int NV   = 4;
    localparam int NO   = 4;
    localparam int VSZ  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [3:0]  grant_ovc;
    logic        send_valid;
    logic [1:0]  send_vc;
    logic        send_tail;
    logic        credit_valid;
    logic [1:0]  credit_ovc;
    logic [3:0]  credit_ok;
    logic [3:0]  ovc_free;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Model: owner = OVC index or -1; state 0 free, 1 busy, 2 drain.
    int         m_owner [NV];
    int         m_cred  [NO];
    int         m_st    [NO];
    int         m_ptr;
    logic [3:0] m_last;
    logic       m_err;
    logic [3:0] e_grant;
    logic [3:0] e_govc;

    always #5 clk = ~clk;

    ovc_allocator dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant        (grant),
        .grant_ovc    (grant_ovc),
        .send_valid   (send_valid),
        .send_vc      (send_vc),
        .send_tail    (send_tail),
        .credit_valid (credit_valid),
        .credit_ovc   (credit_ovc),
        .credit_ok    (credit_ok),
        .ovc_free     (ovc_free),
        .err          (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) m_owner[i] = -1;
        for (int j = 0; j < NO; j++) begin
            m_cred[j] = VSZ;
            m_st[j]   = 0;
        end
        m_ptr = 0; m_last = '0; m_err = 1'b0;
        e_grant = '0; e_govc = 4'hf;
    endtask

    task automatic model_step();
        int win, fre, o, delta [NO], prev_st [NO];
        if (rst) begin
            model_reset();
            return;
        end
        win = -1; fre = -1;
        for (int j = NO - 1; j >= 0; j--) if (m_st[j] == 0) fre = j;
        for (int k = NV - 1; k >= 0; k--) begin
            int i;
            i = (m_ptr + k) % NV;
            if (req[i] && m_owner[i] < 0 && !m_last[i]) win = i;
        end
        for (int j = 0; j < NO; j++) begin
            delta[j]   = 0;
            prev_st[j] = m_st[j];
        end
        o = m_owner[send_vc];
        if (send_valid) begin
            if (o < 0) m_err = 1'b1;
            else       delta[o] -= 1;
        end
        if (credit_valid) delta[credit_ovc] += 1;
        for (int j = 0; j < NO; j++) begin
            if (m_cred[j] + delta[j] > VSZ)    m_err = 1'b1;
            else if (m_cred[j] + delta[j] < 0) m_err = 1'b1;
            else                               m_cred[j] += delta[j];
        end
        if (send_valid && send_tail && o >= 0) begin
            m_owner[send_vc] = -1;
            if (m_st[o] == 1) m_st[o] = (m_cred[o] == VSZ) ? 0 : 2;
        end
        for (int j = 0; j < NO; j++)
            if (prev_st[j] == 2 && m_cred[j] == VSZ) m_st[j] = 0;
        if (win >= 0 && fre >= 0) begin
            e_grant = 4'(1 << win);
            e_govc  = 4'(fre);
            m_st[fre]    = 1;
            m_owner[win] = fre;
            m_ptr        = (win + 1) % NV;
        end else begin
            e_grant = '0;
            e_govc  = 4'hf;
        end
        m_last = e_grant;
    endtask

    task automatic compare_all();
        logic [3:0] e_cok, e_free;
        for (int i = 0; i < NV; i++)
            e_cok[i] = (m_owner[i] >= 0) && (m_cred[m_owner[i]] > 0);
        for (int j = 0; j < NO; j++)
            e_free[j] = (m_st[j] == 0);
        check("grant", 32'(grant), 32'(e_grant));
        check("grant_ovc", 32'(grant_ovc), 32'(e_govc));
        check("credit_ok", 32'(credit_ok), 32'(e_cok));
        check("ovc_free", 32'(ovc_free), 32'(e_free));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        send_valid = 1'b0; send_tail = 1'b0; send_vc = '0;
        credit_valid = 1'b0; credit_ovc = '0;
    endtask

    task automatic do_reset();
        idle(); req = '0; rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic send(input int vc, input logic tail);
        send_valid = 1'b1; send_vc = 2'(vc); send_tail = tail;
        cyc();
        idle();
    endtask

    task automatic ret(input int o);
        credit_valid = 1'b1; credit_ovc = 2'(o);
        cyc();
        idle();
    endtask

    initial begin
        idle(); req = '0; rst = 1'b1;
        model_reset();
        cyc();
        rst = 1'b0;
        check("rst_grant_ovc", 32'(grant_ovc), 32'hf);
        check("rst_ovc_free", 32'(ovc_free), 32'hf);

        // 1: single request
        req = 4'b0001;
        cyc();
        req = '0;
        check("t1_grant", 32'(grant), 32'b0001);
        check("t1_ovc", 32'(grant_ovc), 32'd0);
        check("t1_free", 32'(ovc_free), 32'b1110);
        check("t1_cok", 32'(credit_ok[0]), 32'd1);

        // 2: exhaust and restore credits of OVC0
        for (int n = 0; n < 8; n++) send(0, 1'b0);
        check("t2_cok_zero", 32'(credit_ok[0]), 32'd0);
        ret(0);
        check("t2_cok_back", 32'(credit_ok[0]), 32'd1);
        for (int n = 0; n < 7; n++) ret(0);
        send(0, 1'b1);
        ret(0);
        check("t2_free", 32'(ovc_free), 32'hf);

        // 3: four requesters, then a fifth blocked request
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("t3_grant", 32'(grant), 32'(1 << k));
            check("t3_ovc", 32'(grant_ovc), 32'(k));
            req[k] = 1'b0;
        end
        send(0, 1'b1);
        req[0] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc();
            check("t3_blocked", 32'(grant), 32'd0);
        end
        ret(0);
        cyc();
        check("t3_regrant", 32'(grant), 32'b0001);
        check("t3_regrant_ovc", 32'(grant_ovc), 32'd0);
        req = '0;

        // 4: tail with credits outstanding -> DRAIN, then FREE
        do_reset();
        req = 4'b0001; cyc(); req = '0;
        send(0, 1'b0);
        send(0, 1'b1);
        check("t4_drain", 32'(ovc_free[0]), 32'd0);
        ret(0);
        check("t4_still_drain", 32'(ovc_free[0]), 32'd0);
        ret(0);
        check("t4_free", 32'(ovc_free[0]), 32'd1);
        req = 4'b0010; cyc(); req = '0;
        check("t4_grant_ovc", 32'(grant_ovc), 32'd0);

        // 5: simultaneous send/credit, then overflow
        do_reset();
        req = 4'b0001; cyc(); req = '0;
        for (int n = 0; n < 5; n++) send(0, 1'b0);
        send_valid = 1'b1; send_vc = 2'd0; credit_valid = 1'b1; credit_ovc = 2'd0;
        cyc(); idle();
        for (int n = 0; n < 5; n++) ret(0);
        check("t5_no_err", 32'(err), 32'd0);
        ret(0);
        check("t5_err", 32'(err), 32'd1);
        cyc();
        check("t5_err_sticky", 32'(err), 32'd1);

        // 6: reset with two busy OVCs and a pending request
        do_reset();
        req = 4'b0011; cyc(); cyc(); req = '0;
        send(0, 1'b0); send(1, 1'b0); send(1, 1'b0);
        req = 4'b0100; rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t6_no_grant", 32'(grant), 32'd0);
        check("t6_free", 32'(ovc_free), 32'hf);
        check("t6_cok", 32'(credit_ok), 32'd0);
        cyc();
        req = '0;

        // Random legal traffic with occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int start, pick, co;
            for (int i = 0; i < NV; i++) begin
                if (m_owner[i] >= 0)                    req[i] = 1'b0;
                else if ($urandom_range(3) == 0)        req[i] = 1'b1;
            end
            idle();
            start = $urandom_range(NV - 1);
            pick = -1;
            for (int k = 0; k < NV; k++) begin
                int i;
                i = (start + k) % NV;
                if (pick < 0 && m_owner[i] >= 0 && m_cred[m_owner[i]] > 0) pick = i;
            end
            if (pick >= 0 && $urandom_range(1) == 1) begin
                send_valid = 1'b1;
                send_vc    = 2'(pick);
                send_tail  = ($urandom_range(3) == 0);
            end
            co = $urandom_range(NO - 1);
            if (m_cred[co] < VSZ && $urandom_range(2) != 0) begin
                credit_valid = 1'b1;
                credit_ovc   = 2'(co);
            end
            rst = ($urandom_range(299) == 0);
            cyc();
        end
        rst = 1'b0;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
